game_flow_ctrl: RTL and testbench

//  Top-level game sequencer: freezes/runs the tube generator and bird physics, detects bird-vs-tube/ground/ceiling

---
 rtl/game_flow_ctrl_pkg.sv | 27 ++
 rtl/game_flow_ctrl_if.sv | 28 ++
 rtl/game_flow_ctrl_tube_hit_check.sv | 24 ++
 rtl/game_flow_ctrl.sv | 131 +++++++++++++
 tb/tb_game_flow_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_flow_ctrl_pkg.sv
// Shared constants for the game sequencer: state encodings, playfield geometry, widths.
// Collision math uses 12-bit signed so tube_x < TUBE_W or tube_y < GAP_HALF cannot wrap.
package game_flow_ctrl_pkg;

  localparam int COORD_W     = 10;
  localparam int SCORE_W     = 8;
  localparam int DEATH_TICKS = 20;
  localparam int TIMER_W     = $clog2(DEATH_TICKS);

  localparam logic signed [11:0] BIRD_X    = 12'sd180;
  localparam logic signed [11:0] BIRD_HALF = 12'sd8;
  localparam logic signed [11:0] TUBE_W    = 12'sd40;
  localparam logic signed [11:0] GAP_HALF  = 12'sd50;
  localparam logic signed [11:0] CEIL_Y    = 12'sd10;
  localparam logic signed [11:0] GROUND_Y  = 12'sd440;

  localparam logic [2:0] ST_READY = 3'd0;
  localparam logic [2:0] ST_PLAY  = 3'd1;
  localparam logic [2:0] ST_DYING = 3'd2;
  localparam logic [2:0] ST_OVER  = 3'd3;
  localparam logic [2:0] ST_CLEAR = 3'd4;

  function automatic logic signed [11:0] to_s(input logic [COORD_W-1:0] v);
    return $signed({2'b00, v});
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundle between the game sequencer and its surroundings (button, bird datapath, tube generator).
// master = the surroundings, slave = game_flow_ctrl.
interface game_flow_ctrl_if;

  logic                                    flap;
  logic [game_flow_ctrl_pkg::COORD_W-1:0]  bird_y;
  logic [game_flow_ctrl_pkg::COORD_W-1:0]  tube1_x, tube1_y;
  logic [game_flow_ctrl_pkg::COORD_W-1:0]  tube2_x, tube2_y;
  logic [game_flow_ctrl_pkg::COORD_W-1:0]  tube3_x, tube3_y;
  logic [game_flow_ctrl_pkg::SCORE_W-1:0]  score;
  logic                                    game_end;
  logic                                    tube_clr_n;
  logic                                    flap_pulse;
  logic                                    collide;
  logic [2:0]                              state;
  logic [game_flow_ctrl_pkg::SCORE_W-1:0]  best_score;

  modport master (
    output flap, bird_y, tube1_x, tube1_y, tube2_x, tube2_y, tube3_x, tube3_y, score,
    input  game_end, tube_clr_n, flap_pulse, collide, state, best_score
  );

  modport slave (
    input  flap, bird_y, tube1_x, tube1_y, tube2_x, tube2_y, tube3_x, tube3_y, score,
    output game_end, tube_clr_n, flap_pulse, collide, state, best_score
  );

endinterface

// File: rtl/game_flow_ctrl_tube_hit_check.sv
// Combinational bird-vs-single-tube overlap test. Touching the gap edge exactly is safe;
// touching the tube's left/right column counts as horizontal overlap.
module game_flow_ctrl_tube_hit_check
  import game_flow_ctrl_pkg::*;
(
  input  logic [COORD_W-1:0] bird_y_i,
  input  logic [COORD_W-1:0] tube_x_i,
  input  logic [COORD_W-1:0] tube_y_i,
  output logic               hit_o
);

  logic signed [11:0] by, tx, ty;
  logic               h_ovl, v_out;

  assign by = to_s(bird_y_i);
  assign tx = to_s(tube_x_i);
  assign ty = to_s(tube_y_i);

  assign h_ovl = (BIRD_X + BIRD_HALF >= tx - TUBE_W) && (BIRD_X - BIRD_HALF <= tx);
  assign v_out = (by - BIRD_HALF < ty - GAP_HALF) || (by + BIRD_HALF > ty + GAP_HALF);

  assign hit_o = h_ovl && v_out;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: flap synchroniser, registered collision flag, READY/PLAY/DYING/OVER/CLEAR FSM.
// Define HISCORE_EN to keep a best-score register; otherwise best_score is tied to zero.
//
// state | meaning
// READY | frozen, waiting for a flap to start
// PLAY  | tubes and bird running
// DYING | frozen death hold-off, DEATH_TICKS ticks
// OVER  | frozen, waiting for a flap to restart
// CLEAR | one-tick restart pulse to tubes and bird
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
(
  input  logic                clk10,
  input  logic                clr,
  game_flow_ctrl_if.slave     bus
);

  logic [1:0]         sync_q;
  logic               flap_prev_q;
  logic               flap_pulse_q;
  logic               collide_q;
  logic [2:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               game_end_q;
  logic               tube_clr_n_q;

  logic               hit1, hit2, hit3;
  logic               ceil_hit, ground_hit, hit;

  game_flow_ctrl_tube_hit_check u_hit1 (
    .bird_y_i (bus.bird_y),
    .tube_x_i (bus.tube1_x),
    .tube_y_i (bus.tube1_y),
    .hit_o    (hit1)
  );

  game_flow_ctrl_tube_hit_check u_hit2 (
    .bird_y_i (bus.bird_y),
    .tube_x_i (bus.tube2_x),
    .tube_y_i (bus.tube2_y),
    .hit_o    (hit2)
  );

  game_flow_ctrl_tube_hit_check u_hit3 (
    .bird_y_i (bus.bird_y),
    .tube_x_i (bus.tube3_x),
    .tube_y_i (bus.tube3_y),
    .hit_o    (hit3)
  );

  assign ceil_hit   = (to_s(bus.bird_y) - BIRD_HALF <= CEIL_Y);
  assign ground_hit = (to_s(bus.bird_y) + BIRD_HALF >= GROUND_Y);
  assign hit        = ceil_hit | ground_hit | hit1 | hit2 | hit3;

  // Button is asynchronous: two flops before the edge detector.
  always_ff @(posedge clk10 or negedge clr) begin
    if (!clr) begin
      sync_q       <= 2'b00;
      flap_prev_q  <= 1'b0;
      flap_pulse_q <= 1'b0;
      collide_q    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], bus.flap};
      flap_prev_q  <= sync_q[1];
      flap_pulse_q <= sync_q[1] & ~flap_prev_q;
      collide_q    <= hit;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_READY: if (flap_pulse_q) state_d = ST_PLAY;
      ST_PLAY: begin
        if (collide_q) begin
          state_d = ST_DYING;
          timer_d = TIMER_W'(DEATH_TICKS - 1);
        end
      end
      ST_DYING: begin
        if (timer_q == '0) state_d = ST_OVER;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      ST_OVER:  if (flap_pulse_q) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_READY;
      default:  state_d = ST_READY;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as state_q.
  always_ff @(posedge clk10 or negedge clr) begin
    if (!clr) begin
      state_q      <= ST_READY;
      timer_q      <= '0;
      game_end_q   <= 1'b1;
      tube_clr_n_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      game_end_q   <= (state_d != ST_PLAY);
      tube_clr_n_q <= (state_d != ST_CLEAR);
    end
  end

`ifdef HISCORE_EN
  logic [SCORE_W-1:0] best_q;

  always_ff @(posedge clk10 or negedge clr) begin
    if (!clr) begin
      best_q <= '0;
    end else if (state_q == ST_PLAY && state_d == ST_DYING && bus.score > best_q) begin
      best_q <= bus.score;
    end
  end

  assign bus.best_score = best_q;
`else
  logic unused_score;

  assign unused_score   = ^bus.score;
  assign bus.best_score = '0;
`endif

  assign bus.game_end   = game_end_q;
  assign bus.tube_clr_n = tube_clr_n_q;
  assign bus.flap_pulse = flap_pulse_q;
  assign bus.collide    = collide_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: reset, collision boundaries, flap sync, death timer, restart, clr mid-game.
// Build with HISCORE_EN defined to expect the best-score register.
module tb_game_flow_ctrl;
  import game_flow_ctrl_pkg::*;

  logic clk10 = 1'b0;
  logic clr;
  int   checks = 0;
  int   passed = 0;

`ifdef HISCORE_EN
  localparam logic [7:0] EXP_BEST = 8'd7;
`else
  localparam logic [7:0] EXP_BEST = 8'd0;
`endif

  game_flow_ctrl_if bus_if ();

  game_flow_ctrl dut (
    .clk10 (clk10),
    .clr   (clr),
    .bus   (bus_if.slave)
  );

  always #5 clk10 = ~clk10;

  typedef struct {
    int by;
    int tsel;
    int tx;
    int ty;
    bit exp;
  } coll_vec_t;

  coll_vec_t cvec [19] = '{
    '{240, 1, 600, 240, 1'b0},
    '{240, 1, 190, 240, 1'b0},
    '{282, 1, 190, 240, 1'b0},
    '{283, 1, 190, 240, 1'b1},
    '{198, 1, 190, 240, 1'b0},
    '{197, 1, 190, 240, 1'b1},
    '{240, 1,  30,  20, 1'b0},
    '{240, 1, 172,  20, 1'b1},
    '{240, 1, 171,  20, 1'b0},
    '{240, 1, 228,  20, 1'b1},
    '{240, 1, 229,  20, 1'b0},
    '{300, 2, 190, 240, 1'b1},
    '{300, 3, 190, 240, 1'b1},
    '{ 18, 1, 600, 240, 1'b1},
    '{ 19, 1, 600, 240, 1'b0},
    '{432, 1, 600, 240, 1'b1},
    '{431, 1, 600, 240, 1'b0},
    '{435, 1, 600, 240, 1'b1},
    '{300, 1, 600, 240, 1'b0}
  };

  task automatic tick();
    @(posedge clk10);
    #1;
  endtask

  task automatic far_tubes();
    bus_if.tube1_x = 10'd600; bus_if.tube1_y = 10'd240;
    bus_if.tube2_x = 10'd600; bus_if.tube2_y = 10'd240;
    bus_if.tube3_x = 10'd600; bus_if.tube3_y = 10'd240;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output int n);
    n = 0;
    while (bus_if.state !== st && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int bad;
    clr = 1'b0;
    bus_if.flap = 1'b0;
    bus_if.bird_y = 10'd240;
    bus_if.score = 8'd0;
    far_tubes();
    #12;
    checks++; if (bus_if.state !== ST_READY) $display("FAIL rst_state got %0d exp %0d", bus_if.state, ST_READY); else passed++;
    checks++; if (bus_if.game_end !== 1'b1) $display("FAIL rst_game_end got %b exp 1", bus_if.game_end); else passed++;
    checks++; if (bus_if.tube_clr_n !== 1'b1) $display("FAIL rst_tube_clr_n got %b exp 1", bus_if.tube_clr_n); else passed++;
    checks++; if (bus_if.flap_pulse !== 1'b0) $display("FAIL rst_flap_pulse got %b exp 0", bus_if.flap_pulse); else passed++;
    checks++; if (bus_if.collide !== 1'b0) $display("FAIL rst_collide got %b exp 0", bus_if.collide); else passed++;
    checks++; if (bus_if.best_score !== 8'd0) $display("FAIL rst_best got %0d exp 0", bus_if.best_score); else passed++;
    @(negedge clk10);
    clr = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus_if.state !== ST_READY || bus_if.game_end !== 1'b1 ||
          bus_if.tube_clr_n !== 1'b1 || bus_if.collide !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL idle_50 bad_ticks got %0d exp 0", bad); else passed++;
  endtask

  task automatic test_collision();
    for (int i = 0; i < 19; i++) begin
      far_tubes();
      bus_if.bird_y = 10'(cvec[i].by);
      case (cvec[i].tsel)
        2:       begin bus_if.tube2_x = 10'(cvec[i].tx); bus_if.tube2_y = 10'(cvec[i].ty); end
        3:       begin bus_if.tube3_x = 10'(cvec[i].tx); bus_if.tube3_y = 10'(cvec[i].ty); end
        default: begin bus_if.tube1_x = 10'(cvec[i].tx); bus_if.tube1_y = 10'(cvec[i].ty); end
      endcase
      tick();
      checks++;
      if (bus_if.collide !== cvec[i].exp)
        $display("FAIL collide_vec%0d by=%0d t%0d=(%0d,%0d) got %b exp %b", i, cvec[i].by,
                 cvec[i].tsel, cvec[i].tx, cvec[i].ty, bus_if.collide, cvec[i].exp);
      else passed++;
    end
    checks++; if (bus_if.state !== ST_READY) $display("FAIL collide_ignored_ready got %0d exp %0d", bus_if.state, ST_READY); else passed++;
    far_tubes();
    bus_if.bird_y = 10'd240;
    tick();
  endtask

  task automatic test_flap_start();
    int pulses;
    bus_if.flap = 1'b1;
    tick();
    checks++; if (bus_if.flap_pulse !== 1'b0) $display("FAIL flap_early1 got %b exp 0", bus_if.flap_pulse); else passed++;
    tick();
    checks++; if (bus_if.flap_pulse !== 1'b0) $display("FAIL flap_early2 got %b exp 0", bus_if.flap_pulse); else passed++;
    tick();
    checks++; if (bus_if.flap_pulse !== 1'b1) $display("FAIL flap_latency got %b exp 1", bus_if.flap_pulse); else passed++;
    checks++; if (bus_if.state !== ST_READY) $display("FAIL ready_before_play got %0d exp %0d", bus_if.state, ST_READY); else passed++;
    pulses = 1;
    tick();
    checks++; if (bus_if.state !== ST_PLAY) $display("FAIL start_play got %0d exp %0d", bus_if.state, ST_PLAY); else passed++;
    checks++; if (bus_if.game_end !== 1'b0) $display("FAIL play_game_end got %b exp 0", bus_if.game_end); else passed++;
    for (int i = 0; i < 7; i++) begin
      if (bus_if.flap_pulse === 1'b1) pulses++;
      tick();
    end
    checks++; if (pulses != 1) $display("FAIL held_single_pulse got %0d exp 1", pulses); else passed++;
    bus_if.flap = 1'b0;
    tick();
  endtask

  task automatic test_death();
    int n;
    int pulses;
    bus_if.score = 8'd7;
    bus_if.tube1_x = 10'd190;
    bus_if.tube1_y = 10'd240;
    bus_if.bird_y = 10'd240;
    tick();
    checks++; if (bus_if.collide !== 1'b0) $display("FAIL gap_centre_collide got %b exp 0", bus_if.collide); else passed++;
    bus_if.bird_y = 10'd300;
    tick();
    checks++; if (bus_if.collide !== 1'b1) $display("FAIL tube_collide got %b exp 1", bus_if.collide); else passed++;
    checks++; if (bus_if.state !== ST_PLAY) $display("FAIL play_until_reg got %0d exp %0d", bus_if.state, ST_PLAY); else passed++;
    tick();
    checks++; if (bus_if.state !== ST_DYING) $display("FAIL enter_dying got %0d exp %0d", bus_if.state, ST_DYING); else passed++;
    checks++; if (bus_if.game_end !== 1'b1) $display("FAIL dying_game_end got %b exp 1", bus_if.game_end); else passed++;
    checks++; if (bus_if.best_score !== EXP_BEST) $display("FAIL best_first got %0d exp %0d", bus_if.best_score, EXP_BEST); else passed++;
    bus_if.flap = 1'b1;
    wait_state(ST_OVER, 40, n);
    checks++; if (bus_if.state !== ST_OVER || n != 20) $display("FAIL death_ticks got %0d (state %0d) exp 20", n, bus_if.state); else passed++;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus_if.flap_pulse === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) $display("FAIL held_from_dying_pulses got %0d exp 0", pulses); else passed++;
    checks++; if (bus_if.state !== ST_OVER) $display("FAIL over_hold got %0d exp %0d", bus_if.state, ST_OVER); else passed++;
  endtask

  task automatic test_restart();
    int n;
    bus_if.bird_y = 10'd240;
    bus_if.flap = 1'b0;
    repeat (4) tick();
    bus_if.flap = 1'b1;
    wait_state(ST_CLEAR, 8, n);
    checks++; if (bus_if.state !== ST_CLEAR) $display("FAIL clear_state got %0d exp %0d", bus_if.state, ST_CLEAR); else passed++;
    checks++; if (bus_if.tube_clr_n !== 1'b0) $display("FAIL clear_pulse got %b exp 0", bus_if.tube_clr_n); else passed++;
    checks++; if (bus_if.game_end !== 1'b1) $display("FAIL clear_game_end got %b exp 1", bus_if.game_end); else passed++;
    bus_if.flap = 1'b0;
    tick();
    checks++; if (bus_if.state !== ST_READY) $display("FAIL clear_to_ready got %0d exp %0d", bus_if.state, ST_READY); else passed++;
    checks++; if (bus_if.tube_clr_n !== 1'b1) $display("FAIL clear_one_tick got %b exp 1", bus_if.tube_clr_n); else passed++;
    checks++; if (bus_if.best_score !== EXP_BEST) $display("FAIL best_survives_clear got %0d exp %0d", bus_if.best_score, EXP_BEST); else passed++;
    bus_if.score = 8'd5;
    bus_if.flap = 1'b1;
    tick();
    bus_if.flap = 1'b0;
    wait_state(ST_PLAY, 8, n);
    checks++; if (bus_if.state !== ST_PLAY) $display("FAIL second_play got %0d exp %0d", bus_if.state, ST_PLAY); else passed++;
    bus_if.bird_y = 10'd300;
    wait_state(ST_DYING, 6, n);
    checks++; if (bus_if.state !== ST_DYING) $display("FAIL second_dying got %0d exp %0d", bus_if.state, ST_DYING); else passed++;
    checks++; if (bus_if.best_score !== EXP_BEST) $display("FAIL best_kept got %0d exp %0d", bus_if.best_score, EXP_BEST); else passed++;
  endtask

  task automatic test_clr_mid_dying();
    int n;
    int bad;
    repeat (3) tick();
    #2;
    clr = 1'b0;
    #1;
    checks++; if (bus_if.state !== ST_READY) $display("FAIL async_clr_state got %0d exp %0d", bus_if.state, ST_READY); else passed++;
    checks++; if (bus_if.game_end !== 1'b1) $display("FAIL async_clr_game_end got %b exp 1", bus_if.game_end); else passed++;
    checks++; if (bus_if.collide !== 1'b0) $display("FAIL async_clr_collide got %b exp 0", bus_if.collide); else passed++;
    checks++; if (bus_if.best_score !== 8'd0) $display("FAIL async_clr_best got %0d exp 0", bus_if.best_score); else passed++;
    bus_if.bird_y = 10'd240;
    @(negedge clk10);
    clr = 1'b1;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus_if.state !== ST_READY) bad++;
    end
    checks++; if (bad != 0) $display("FAIL stay_ready_after_clr bad_ticks got %0d exp 0", bad); else passed++;
    bus_if.flap = 1'b1;
    tick();
    bus_if.flap = 1'b0;
    wait_state(ST_PLAY, 8, n);
    bus_if.bird_y = 10'd300;
    wait_state(ST_DYING, 6, n);
    checks++; if (bus_if.state !== ST_DYING) $display("FAIL third_dying got %0d exp %0d", bus_if.state, ST_DYING); else passed++;
    wait_state(ST_OVER, 40, n);
    checks++; if (bus_if.state !== ST_OVER || n != 20) $display("FAIL death_ticks_after_clr got %0d (state %0d) exp 20", n, bus_if.state); else passed++;
  endtask

  initial begin
    test_reset();
    test_collision();
    test_flap_start();
    test_death();
    test_restart();
    test_clr_mid_dying();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
